// File: rtl/pkt_rd_pkg.sv
// -----------------------------------------------------------------------------
// pkt_rd_pkg
// Shared definitions for the packet read server: field widths, the read
// command layout, FSM state encoding, data-return FIFO depth and a helper
// for computing beat addresses.
// Widths: ADDR_W (buffer word address width, 8) and DATA_W (data beat
// width, 32).
// -----------------------------------------------------------------------------
package pkt_rd_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam int PORT_W     = 4;
  localparam int LEN_W      = 4;
  localparam int CMD_W      = ADDR_W + LEN_W + PORT_W + 1;
  localparam int STAT_W     = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Command layout, MSB first: {addr, len, dst_port, drop}; drop is the LSB.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [PORT_W-1:0] dst_port;
    logic              drop;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FREE  = 2'd3
  } state_e;

  // Address of beat idx of a packet starting at base; wraps at top of buffer.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/pkt_rd_server_if.sv
// -----------------------------------------------------------------------------
// pkt_rd_server_if
// Bundles every non-clock/reset signal of pkt_rd_server. Signal names keep
// their direction prefix as seen from the server (i* = into server).
//   slave  : the server side
//   master : the environment side (command source, SRAM, data sink, free mgr)
// -----------------------------------------------------------------------------
interface pkt_rd_server_if;
  import pkt_rd_pkg::*;

  // Read command channel
  logic              iCmdVld;
  logic              oCmdRdy;
  logic [CMD_W-1:0]  iCmdPld;
  // Packet SRAM read port
  logic              oMemRe;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] iMemRdata;
  // Data return channel
  logic              oDataVld;
  logic              iDataRdy;
  logic [DATA_W:0]   oDataPld;
  logic [PORT_W-1:0] oDataDst;
  // Free-address channel
  logic              oFreeVld;
  logic              iFreeRdy;
  logic [ADDR_W-1:0] oFreeAddr;
  // Statistics
  logic [STAT_W-1:0] oPktCnt;
  logic [STAT_W-1:0] oDropCnt;

  modport slave (
    input  iCmdVld, iCmdPld, iMemRdata, iDataRdy, iFreeRdy,
    output oCmdRdy, oMemRe, oMemAddr, oDataVld, oDataPld, oDataDst,
           oFreeVld, oFreeAddr, oPktCnt, oDropCnt
  );

  modport master (
    output iCmdVld, iCmdPld, iMemRdata, iDataRdy, iFreeRdy,
    input  oCmdRdy, oMemRe, oMemAddr, oDataVld, oDataPld, oDataDst,
           oFreeVld, oFreeAddr, oPktCnt, oDropCnt
  );

endinterface

// File: rtl/pkt_rd_fifo.sv
// -----------------------------------------------------------------------------
// pkt_rd_fifo
// Two-entry FIFO whose head entry is a register driving the output directly,
// so a word pushed into an empty FIFO is visible the next cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push, din : write strobe and data
//   pop       : read strobe (ignored when empty)
//   out_vld   : head entry valid
//   out_data  : head entry data
//   cnt       : occupancy (0..2)
// A push while full without a pop is discarded; the caller's credit scheme
// guarantees that never happens.
// -----------------------------------------------------------------------------
module pkt_rd_fifo
  import pkt_rd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop,
  output logic                  out_vld,
  output logic [W-1:0]          out_data,
  output logic [FIFO_CNT_W-1:0] cnt
);

  logic [W-1:0]          head_q, head_d;
  logic [W-1:0]          tail_q, tail_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pop_ok;

  assign pop_ok = pop && (cnt_q != 2'd0);

  // Next-state for head/tail registers and occupancy.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = din;
          cnt_d  = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop_ok) begin
          head_d = din;
        end else if (push) begin
          tail_d = din;
          cnt_d  = 2'd2;
        end else if (pop_ok) begin
          cnt_d = 2'd0;
        end else begin
          cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_ok) begin
          head_d = tail_q;
          if (push) begin
            tail_d = din;
          end else begin
            cnt_d = 2'd1;
          end
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_vld  = (cnt_q != 2'd0);
  assign out_data = head_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/pkt_rd_server.sv
// -----------------------------------------------------------------------------
// pkt_rd_server
// Single-channel packet-buffer read server. Accepts one read command at a
// time, fetches len+1 beats from the synchronous packet SRAM starting at the
// command address (wrapping at the top of the buffer), streams them out as
// {data, last} and then hands the start address back to the free manager.
// Dropped commands skip the SRAM and go straight to the free handshake.
// Ports:
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : pkt_rd_server_if.slave (command, SRAM, data, free, stats)
// Build option: PKT_RD_SRV_STAT_EN enables the 16-bit packet/drop counters;
// without it oPktCnt/oDropCnt are constant zero.
// -----------------------------------------------------------------------------
module pkt_rd_server
  import pkt_rd_pkg::*;
(
  input  logic            iClk,
  input  logic            iRst,
  pkt_rd_server_if.slave  bus
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              rd_vld_q, rd_vld_d;    // SRAM read issued last cycle
  logic              rd_last_q, rd_last_d;  // that read was beat N
  logic              rdy_q, rdy_d;

  logic                  fifo_pop;
  logic                  fifo_vld;
  logic [DATA_W:0]       fifo_data;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [2:0]            credit_use;
  logic                  mem_re;
  logic                  last_issue;
  logic                  cmd_acc;
  logic                  last_acc;
  logic                  free_acc;

  assign fifo_pop = fifo_vld && bus.iDataRdy;
  assign last_acc = fifo_pop && fifo_data[0];
  assign cmd_acc  = rdy_q && bus.iCmdVld;
  assign free_acc = (state_q == ST_FREE) && bus.iFreeRdy;

  // Slots committed at the end of this cycle: occupancy after this cycle's
  // pop plus the read landing now. A read issued now lands next cycle, so
  // this must leave a free slot even if the sink stalls from then on.
  assign credit_use = 3'(fifo_cnt) + {2'b00, rd_vld_q} - {2'b00, fifo_pop};
  assign mem_re     = (state_q == ST_READ) && (credit_use < 3'(FIFO_DEPTH));
  assign last_issue = mem_re && (beat_q == cmd_q.len);

  // FSM next-state and command/beat bookkeeping.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    beat_d    = beat_q;
    rd_vld_d  = mem_re;
    rd_last_d = last_issue;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          cmd_d   = cmd_t'(bus.iCmdPld);
          beat_d  = '0;
          state_d = bus.iCmdPld[0] ? ST_FREE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (mem_re) begin
          beat_d  = beat_q + 4'd1;
          state_d = last_issue ? ST_DRAIN : ST_READ;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (last_acc) begin
          state_d = ST_FREE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FREE: begin
        if (free_acc) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is registered so it stays low throughout reset.
    rdy_d = (state_d == ST_IDLE);
  end

  // Control state registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      beat_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      beat_q    <= beat_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      rdy_q     <= rdy_d;
    end
  end

  // SRAM data is captured the cycle after the read, tagged with its last flag.
  pkt_rd_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk      (iClk),
    .rst      (iRst),
    .push     (rd_vld_q),
    .din      ({bus.iMemRdata, rd_last_q}),
    .pop      (fifo_pop),
    .out_vld  (fifo_vld),
    .out_data (fifo_data),
    .cnt      (fifo_cnt)
  );

  assign bus.oCmdRdy   = rdy_q;
  assign bus.oMemRe    = mem_re;
  assign bus.oMemAddr  = beat_addr(cmd_q.addr, beat_q);
  assign bus.oDataVld  = fifo_vld;
  assign bus.oDataPld  = fifo_data;
  assign bus.oDataDst  = cmd_q.dst_port;
  assign bus.oFreeVld  = (state_q == ST_FREE);
  assign bus.oFreeAddr = cmd_q.addr;

`ifdef PKT_RD_SRV_STAT_EN
  logic [STAT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Counters advance on the free handshake; they wrap naturally.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (free_acc) begin
      if (cmd_q.drop) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
    end else begin
      pkt_cnt_d  = pkt_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.oPktCnt  = pkt_cnt_q;
  assign bus.oDropCnt = drop_cnt_q;
`else
  assign bus.oPktCnt  = '0;
  assign bus.oDropCnt = '0;
`endif

endmodule

// File: tb/tb_pkt_rd_server.sv
// -----------------------------------------------------------------------------
// tb_pkt_rd_server
// Directed self-checking bench for pkt_rd_server. An SRAM model returns a
// known word per address; monitors log reads, beats and free handshakes with
// their cycle numbers, and each scenario compares the logs to hand-derived
// expectations.
// -----------------------------------------------------------------------------
module tb_pkt_rd_server;
  import pkt_rd_pkg::*;

`ifdef PKT_RD_SRV_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_rd_server_if bus();

  pkt_rd_server dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] rdy_pat = 32'b1011_0010_0111_0100_1100_1010_0011_1101;

  logic [ADDR_W-1:0] rd_addr_q[$];
  int                rd_cyc_q[$];
  logic [DATA_W:0]   beat_pld_q[$];
  int                beat_cyc_q[$];
  logic [PORT_W-1:0] beat_dst_q[$];
  logic [ADDR_W-1:0] free_addr_q[$];
  int                free_cyc_q[$];
  logic              hold_vld = 1'b0;
  logic [DATA_W:0]   held_pld;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {8'hC3, 8'(a), ~8'(a), 8'(a) ^ 8'h5A};
    return DATA_W'(w);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous SRAM model, one-cycle read latency
  always @(posedge clk) if (bus.oMemRe) bus.iMemRdata <= mem_word(bus.oMemAddr);

  // monitors sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
    end else begin
      if (hold_vld) begin
        check_eq("hold_vld", bus.oDataVld, 1'b1);
        check_eq("hold_pld", bus.oDataPld, held_pld);
      end
      hold_vld <= bus.oDataVld && !bus.iDataRdy;
      held_pld <= bus.oDataPld;
      if (bus.oMemRe) begin
        rd_addr_q.push_back(bus.oMemAddr);
        rd_cyc_q.push_back(cyc);
      end
      if (bus.oDataVld && bus.iDataRdy) begin
        beat_pld_q.push_back(bus.oDataPld);
        beat_cyc_q.push_back(cyc);
        beat_dst_q.push_back(bus.oDataDst);
      end
      if (bus.oFreeVld && bus.iFreeRdy) begin
        free_addr_q.push_back(bus.oFreeAddr);
        free_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete();
    beat_pld_q.delete(); beat_cyc_q.delete(); beat_dst_q.delete();
    free_addr_q.delete(); free_cyc_q.delete();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_cmd_rdy", bus.oCmdRdy, 1'b0);
    check_eq("rst_mem_re", bus.oMemRe, 1'b0);
    check_eq("rst_mem_addr", bus.oMemAddr, '0);
    check_eq("rst_data_vld", bus.oDataVld, 1'b0);
    check_eq("rst_data_pld", bus.oDataPld, '0);
    check_eq("rst_data_dst", bus.oDataDst, '0);
    check_eq("rst_free_vld", bus.oFreeVld, 1'b0);
    check_eq("rst_free_addr", bus.oFreeAddr, '0);
    check_eq("rst_pkt_cnt", bus.oPktCnt, 16'd0);
    check_eq("rst_drop_cnt", bus.oDropCnt, 16'd0);
  endtask

  // Returns t = the cycle in which the command handshake happens.
  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                          input logic [PORT_W-1:0] dst, input logic drop, output int t);
    int n;
    n = 0;
    while (!bus.oCmdRdy && n < 50) begin
      tick();
      n++;
    end
    check_eq("cmd_rdy", bus.oCmdRdy, 1'b1);
    bus.iCmdVld = 1'b1;
    bus.iCmdPld = {a, len, dst, drop};
    t = cyc;
    tick();
    bus.iCmdVld = 1'b0;
  endtask

  // Runs until the free handshake is logged, optionally toggling iDataRdy.
  task automatic run_pkt(input bit toggle, input int budget);
    int start;
    int n;
    start = free_addr_q.size();
    n = 0;
    while (free_addr_q.size() == start && n < budget) begin
      bus.iDataRdy = toggle ? rdy_pat[cyc % 32] : 1'b1;
      tick();
      n++;
    end
    check_eq("pkt_done", free_addr_q.size() > start, 1'b1);
    bus.iDataRdy = 1'b1;
  endtask

  // t < 0 skips cycle-exact timing checks.
  task automatic check_beats(input logic [ADDR_W-1:0] base, input int n,
                             input logic [PORT_W-1:0] dst, input int t);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W:0]   ep;
    check_eq("rd_count", rd_addr_q.size(), n);
    check_eq("beat_count", beat_pld_q.size(), n);
    for (int k = 0; k < n; k++) begin
      ea = base + ADDR_W'(k);
      ep = {mem_word(ea), (k == n - 1)};
      if (k < rd_addr_q.size()) begin
        check_eq("rd_addr", rd_addr_q[k], ea);
        if (t >= 0) check_eq("rd_cyc", rd_cyc_q[k], t + 1 + k);
      end
      if (k < beat_pld_q.size()) begin
        check_eq("beat_pld", beat_pld_q[k], ep);
        check_eq("beat_dst", beat_dst_q[k], dst);
        if (t >= 0) check_eq("beat_cyc", beat_cyc_q[k], t + 3 + k);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [ADDR_W-1:0] top_base;
    rst          = 1'b1;
    bus.iCmdVld  = 1'b0;
    bus.iCmdPld  = '0;
    bus.iDataRdy = 1'b1;
    bus.iFreeRdy = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    tick();
    check_eq("rdy_after_rst", bus.oCmdRdy, 1'b1);

    // single packet, 4 beats
    clear_logs();
    send_cmd(8'h10, 4'd3, 4'd3, 1'b0, t);
    run_pkt(1'b0, 40);
    check_beats(8'h10, 4, 4'd3, t);
    check_eq("p1_free_addr", free_addr_q[0], 8'h10);
    check_eq("p1_free_cyc", free_cyc_q[0], t + 7);
    tick();
    check_eq("p1_pkt_cnt", bus.oPktCnt, STAT ? 16'd1 : 16'd0);

    // dropped command
    clear_logs();
    send_cmd(8'h20, 4'd5, 4'd1, 1'b1, t);
    run_pkt(1'b0, 10);
    check_eq("drop_rd_count", rd_addr_q.size(), 0);
    check_eq("drop_beat_count", beat_pld_q.size(), 0);
    check_eq("drop_free_addr", free_addr_q[0], 8'h20);
    check_eq("drop_free_cyc", free_cyc_q[0], t + 1);
    tick();
    check_eq("drop_cnt", bus.oDropCnt, STAT ? 16'd1 : 16'd0);
    check_eq("drop_pkt_cnt", bus.oPktCnt, STAT ? 16'd1 : 16'd0);

    // 16 beats with downstream backpressure
    clear_logs();
    send_cmd(8'h40, 4'd15, 4'hA, 1'b0, t);
    run_pkt(1'b1, 200);
    check_beats(8'h40, 16, 4'hA, -1);
    check_eq("p3_free_addr", free_addr_q[0], 8'h40);

    // address wrap at top of buffer
    clear_logs();
    top_base = '1;
    top_base = top_base - 1'b1;
    send_cmd(top_base, 4'd3, 4'd2, 1'b0, t);
    run_pkt(1'b0, 40);
    check_beats(top_base, 4, 4'd2, t);
    tick();
    check_eq("wrap_pkt_cnt", bus.oPktCnt, STAT ? 16'd3 : 16'd0);

    // free channel backpressure
    clear_logs();
    bus.iFreeRdy = 1'b0;
    send_cmd(8'h33, 4'd0, 4'd0, 1'b1, t);
    for (int i = 0; i < 5; i++) begin
      check_eq("fbp_free_vld", bus.oFreeVld, 1'b1);
      check_eq("fbp_free_addr", bus.oFreeAddr, 8'h33);
      check_eq("fbp_cmd_rdy", bus.oCmdRdy, 1'b0);
      tick();
    end
    bus.iFreeRdy = 1'b1;
    check_eq("fbp_free_vld_last", bus.oFreeVld, 1'b1);
    tick();
    check_eq("fbp_rdy_after", bus.oCmdRdy, 1'b1);
    check_eq("fbp_free_vld_off", bus.oFreeVld, 1'b0);
    check_eq("fbp_free_cyc", free_cyc_q.size() > 0 ? free_cyc_q[0] : -1, t + 6);
    check_eq("fbp_drop_cnt", bus.oDropCnt, STAT ? 16'd2 : 16'd0);

    // reset during beat 2 of a 4-beat packet
    clear_logs();
    send_cmd(8'h50, 4'd3, 4'd6, 1'b0, t);
    while (cyc < t + 4) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    check_eq("abort_beats", beat_pld_q.size(), 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("abort_rdy", bus.oCmdRdy, 1'b1);
    repeat (3) tick();
    check_eq("abort_no_free", free_addr_q.size(), 0);
    check_eq("abort_no_vld", bus.oDataVld, 1'b0);
    clear_logs();
    send_cmd(8'h60, 4'd1, 4'd5, 1'b0, t);
    run_pkt(1'b0, 20);
    check_beats(8'h60, 2, 4'd5, t);
    check_eq("post_free_addr", free_addr_q[0], 8'h60);
    check_eq("post_free_cyc", free_cyc_q[0], t + 5);
    tick();
    check_eq("post_pkt_cnt", bus.oPktCnt, STAT ? 16'd1 : 16'd0);
    check_eq("post_drop_cnt", bus.oDropCnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
